commit_arbiter: RTL and testbench
=================================

COMMIT_ARBITER -- requirements
Module: commit_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one vector component (x/y/z).
REQ-002 SHALL have parameter DST_W, default 7, destination register address width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 Clock  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high.
REQ-006 iCommitRequest  input  5  per-station commit request; bit0 ADD_0, bit1 ADD_1, bit2 DIV, bit3 MUL, bit4 SQRT.
REQ-007 iCommitData  input  5*E  per-station commit payload; E = DST_W+3+3*DATA_W; slot i at [i*E +: E], fields {dst, we[2:0], x, y, z} MSB-first.
REQ-008 oCommitGranted  output  5  one-hot grant; routes to each station's iCommitGranted.
REQ-009 oWriteEnable  output  1  register-file write strobe.
REQ-010 oWriteAddress  output  DST_W  register-file write address.
REQ-011 oWriteMask  output  3  component write enables {x,y,z}.
REQ-012 oWriteData  output  3*DATA_W  {x,y,z} write data.
REQ-013 oCommitValid  output  1  commit broadcast valid, for station operand forwarding/tag release.
REQ-014 oCommitRsId  output  4  committing station, `RS_ADD0/`RS_ADD1/`RS_DIV/`RS_MUL/`RS_SQRT codes; 0 when idle.
REQ-015 oCommitCount  output  16  total commits since reset.

Function
REQ-016 Grant SHALL be combinational from iCommitRequest and round-robin pointer rPtr (0..4); at most one bit of oCommitGranted SHALL be set.
REQ-017 Winner SHALL be the first requesting index at or after rPtr, searching rPtr, rPtr+1, ... modulo 5.
REQ-018 No request bit set SHALL give oCommitGranted = 0, rPtr unchanged.
REQ-019 On a grant to index w, rPtr SHALL become (w+1) mod 5 at the next edge; 4 wraps to 0.
REQ-020 Granted slot's payload SHALL be registered at the grant edge; oWriteAddress/oWriteMask/oWriteData/oCommitRsId valid in the following cycle (latency 1).
REQ-021 oCommitValid SHALL be 1 in the cycle after any grant, else 0.
REQ-022 oWriteEnable SHALL equal oCommitValid AND (oWriteMask != 000); a mask-000 commit broadcasts but does not write.
REQ-023 While oCommitValid = 0, oWriteAddress, oWriteMask, oWriteData SHALL hold their last values; oCommitRsId SHALL be 0.
REQ-024 Handshake: a station holds request and payload until granted and deasserts in the cycle after grant; a request still high after its grant SHALL be treated as a new commit.
REQ-025 Payload of non-granted slots SHALL be ignored.
REQ-026 oCommitCount SHALL increment by 1 per grant and wrap 0xFFFF -> 0x0000.
REQ-027 All five requesting continuously SHALL yield grants in rotation; no station waits more than 4 cycles from request to grant.

Reset
REQ-028 While Reset = 1, oCommitGranted SHALL be forced to 0 combinationally.
REQ-029 At a Reset edge: rPtr = 0, oCommitValid = 0, oWriteEnable = 0, oCommitRsId = 0, oWriteAddress = 0, oWriteMask = 000, oWriteData = 0, oCommitCount = 0.
REQ-030 Reset asserted in the cycle after a grant SHALL discard that commit; a pending request SHALL be granted again after Reset deasserts.

Verification
REQ-031 Single request: MUL requests, dst=5, we=111, x/y/z=1,2,3 -> oCommitGranted=01000 same cycle; next cycle oWriteEnable=1, addr 5, mask 111, data {1,2,3}, oCommitRsId=`RS_MUL, count=1.
REQ-032 All five request continuously from reset -> grant order ADD_0, ADD_1, DIV, MUL, SQRT, ADD_0; oCommitValid high every cycle.
REQ-033 rPtr=3 (after DIV grant), ADD_0 and SQRT request -> SQRT granted first, ADD_0 next cycle, rPtr ends at 1.
REQ-034 ADD_1 commits we=000 -> oCommitValid=1, oWriteEnable=0, oCommitRsId=`RS_ADD1, count increments.
REQ-035 Reset high the cycle after a DIV grant -> oCommitValid=0, count=0, rPtr=0, no grant while Reset high; DIV still requesting after Reset -> granted first cycle out.
REQ-036 Force 65536 commits -> oCommitCount wraps to 0x0000.

Source files
------------

// File: rtl/commit_arbiter.sv
// commit_arbiter: picks one of five reservation stations per cycle to commit
// its result. Arbitration is round-robin and purely combinational. The winning
// payload is registered and presented one cycle later as a register-file write
// and as a commit broadcast.
//
// Ports:
//   Clock, Reset          single clock, synchronous active-high reset
//   iCommitRequest[4:0]   per-station request {SQRT, MUL, DIV, ADD_1, ADD_0}
//   iCommitData           five packed payloads {dst, we[2:0], x, y, z}
//   oCommitGranted[4:0]   one-hot grant (combinational)
//   oWriteEnable          register-file write strobe
//   oWriteAddress         register-file write address
//   oWriteMask[2:0]       component write enables {x, y, z}
//   oWriteData            write data {x, y, z}
//   oCommitValid          commit broadcast valid
//   oCommitRsId[3:0]      committing station code, 0 when idle
//   oCommitCount[15:0]    commits since reset (wraps)
module commit_arbiter #(
  parameter int DATA_W = 32,
  parameter int DST_W  = 7
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic [4:0]                          iCommitRequest,
  input  logic [5*(DST_W+3+3*DATA_W)-1:0]     iCommitData,
  output logic [4:0]                          oCommitGranted,
  output logic                                oWriteEnable,
  output logic [DST_W-1:0]                    oWriteAddress,
  output logic [2:0]                          oWriteMask,
  output logic [3*DATA_W-1:0]                 oWriteData,
  output logic                                oCommitValid,
  output logic [3:0]                          oCommitRsId,
  output logic [15:0]                         oCommitCount
);

  localparam int E = DST_W + 3 + 3*DATA_W;

  typedef enum logic [3:0] {
    RS_NONE = 4'd0,
    RS_ADD0 = 4'd1,
    RS_ADD1 = 4'd2,
    RS_DIV  = 4'd3,
    RS_MUL  = 4'd4,
    RS_SQRT = 4'd5
  } rs_id_e;

  logic [2:0]          ptr_q, ptr_d;
  logic                valid_q, valid_d;
  rs_id_e              rsid_q, rsid_d;
  logic [DST_W-1:0]    addr_q, addr_d;
  logic [2:0]          mask_q, mask_d;
  logic [3*DATA_W-1:0] data_q, data_d;
  logic [15:0]         count_q, count_d;

  logic [4:0]          grant;
  logic                found;
  logic [2:0]          win;
  logic [3:0]          idx;
  logic [E-1:0]        slot_sel;

  // Round-robin search starting at the pointer; the first hit wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && iCommitRequest[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
    if (Reset) found = 1'b0;
    grant = '0;
    if (found) grant[win] = 1'b1;
  end

  // One-hot payload mux: only the granted slot contributes.
  always_comb begin
    slot_sel = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (grant[i]) slot_sel = iCommitData[i*E +: E];
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    valid_d = found;
    rsid_d  = RS_NONE;
    addr_d  = addr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    count_d = count_q;
    if (found) begin
      ptr_d   = (win == 3'd4) ? 3'd0 : win + 3'd1;
      rsid_d  = rs_id_e'({1'b0, win} + 4'd1);
      addr_d  = slot_sel[E-1 -: DST_W];
      mask_d  = slot_sel[3*DATA_W +: 3];
      data_d  = slot_sel[3*DATA_W-1:0];
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      rsid_q  <= RS_NONE;
      addr_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      rsid_q  <= rsid_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign oCommitGranted = grant;
  assign oCommitValid   = valid_q;
  assign oWriteEnable   = valid_q & (|mask_q);
  assign oWriteAddress  = addr_q;
  assign oWriteMask     = mask_q;
  assign oWriteData     = data_q;
  assign oCommitRsId    = rsid_q;
  assign oCommitCount   = count_q;

endmodule

// File: tb/tb_commit_arbiter.sv
// Testbench for commit_arbiter: table of request patterns with hand-derived
// grants, a scoreboard of expected commits checked one cycle later, and
// directed sequences for reset discard and count wrap.
module tb_commit_arbiter;

  localparam int DATA_W = 32;
  localparam int DST_W  = 7;
  localparam int E      = DST_W + 3 + 3*DATA_W;

  logic                clk;
  logic                rst;
  logic [4:0]          req;
  logic [5*E-1:0]      cdata;
  logic [4:0]          gnt;
  logic                we_o;
  logic [DST_W-1:0]    addr_o;
  logic [2:0]          mask_o;
  logic [3*DATA_W-1:0] data_o;
  logic                valid_o;
  logic [3:0]          rsid_o;
  logic [15:0]         cnt_o;

  commit_arbiter #(.DATA_W(DATA_W), .DST_W(DST_W)) dut (
    .Clock          (clk),
    .Reset          (rst),
    .iCommitRequest (req),
    .iCommitData    (cdata),
    .oCommitGranted (gnt),
    .oWriteEnable   (we_o),
    .oWriteAddress  (addr_o),
    .oWriteMask     (mask_o),
    .oWriteData     (data_o),
    .oCommitValid   (valid_o),
    .oCommitRsId    (rsid_o),
    .oCommitCount   (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] req;
    logic [2:0] we;
    logic [4:0] exp_gnt;
  } vec_t;

  typedef struct {
    logic [DST_W-1:0]    dst;
    logic [2:0]          mask;
    logic [3*DATA_W-1:0] data;
    logic [3:0]          rsid;
  } cm_t;

  cm_t sbq[$];

  int          checks = 0;
  int          errors = 0;
  int          stepn  = 0;
  int          mptr   = 0;
  logic [15:0] mcount = '0;

  logic [DST_W-1:0]    last_addr = '0;
  logic [2:0]          last_mask = '0;
  logic [3*DATA_W-1:0] last_data = '0;

  logic [DST_W-1:0]    pd_dst [5];
  logic [2:0]          pd_we  [5];
  logic [3*DATA_W-1:0] pd_xyz [5];

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", n, a, e, stepn);
    end
  endtask

  function automatic logic [4:0] model_gnt(input logic [4:0] r, input int p);
    for (int k = 0; k < 5; k++) begin
      int ix;
      ix = (p + k) % 5;
      if (r[ix]) return 5'(1 << ix);
    end
    return 5'b0;
  endfunction

  // One clock cycle: check the registered outputs from the last edge, drive new
  // inputs, check the combinational grant, and update the model.
  task automatic step(input logic r, input logic [4:0] rq, input logic [2:0] we,
                      input logic [4:0] exp, input bit mul_special);
    cm_t e;
    logic [31:0] x;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("valid",  {127'b0, valid_o}, 128'd1);
      chk("rsid",   {124'b0, rsid_o},  {124'b0, e.rsid});
      chk("addr",   {121'b0, addr_o},  {121'b0, e.dst});
      chk("mask",   {125'b0, mask_o},  {125'b0, e.mask});
      chk("data",   {32'b0, data_o},   {32'b0, e.data});
      chk("we",     {127'b0, we_o},    {127'b0, (e.mask != 3'b000)});
      last_addr = e.dst;
      last_mask = e.mask;
      last_data = e.data;
    end else begin
      chk("idle_valid", {127'b0, valid_o}, 128'd0);
      chk("idle_we",    {127'b0, we_o},    128'd0);
      chk("idle_rsid",  {124'b0, rsid_o},  128'd0);
      chk("hold_addr",  {121'b0, addr_o},  {121'b0, last_addr});
      chk("hold_mask",  {125'b0, mask_o},  {125'b0, last_mask});
      chk("hold_data",  {32'b0, data_o},   {32'b0, last_data});
    end
    chk("count", {112'b0, cnt_o}, {112'b0, mcount});

    for (int i = 0; i < 5; i++) begin
      x = 32'(stepn*100 + i);
      pd_dst[i] = 7'(stepn*5 + i);
      pd_we[i]  = we;
      pd_xyz[i] = {x, ~x, x ^ 32'hA5A5A5A5};
      if (mul_special && i == 3) begin
        pd_dst[i] = 7'd5;
        pd_we[i]  = 3'b111;
        pd_xyz[i] = {32'd1, 32'd2, 32'd3};
      end
      cdata[i*E +: E] = {pd_dst[i], pd_we[i], pd_xyz[i]};
    end
    rst = r;
    req = rq;
    #1;
    chk("grant", {123'b0, gnt}, {123'b0, exp});

    if (r) begin
      sbq.delete();
      mcount    = '0;
      mptr      = 0;
      last_addr = '0;
      last_mask = '0;
      last_data = '0;
    end else if (exp != 5'b0) begin
      for (int i = 0; i < 5; i++) begin
        if (exp[i]) begin
          e.dst  = pd_dst[i];
          e.mask = pd_we[i];
          e.data = pd_xyz[i];
          e.rsid = 4'(i + 1);
          sbq.push_back(e);
          mptr = (i + 1) % 5;
        end
      end
      mcount = mcount + 16'd1;
    end
    stepn++;
  endtask

  vec_t tbl[15];

  initial begin
    // Pointer is 4 when the table starts (after the single MUL commit).
    tbl[0]  = '{5'b11111, 3'b111, 5'b10000};
    tbl[1]  = '{5'b11111, 3'b101, 5'b00001};
    tbl[2]  = '{5'b11111, 3'b010, 5'b00010};
    tbl[3]  = '{5'b11111, 3'b111, 5'b00100};
    tbl[4]  = '{5'b11111, 3'b100, 5'b01000};
    tbl[5]  = '{5'b11111, 3'b001, 5'b10000};
    tbl[6]  = '{5'b11111, 3'b111, 5'b00001};
    tbl[7]  = '{5'b00000, 3'b111, 5'b00000};
    tbl[8]  = '{5'b00010, 3'b000, 5'b00010};
    tbl[9]  = '{5'b00100, 3'b110, 5'b00100};
    tbl[10] = '{5'b10001, 3'b111, 5'b10000};
    tbl[11] = '{5'b10001, 3'b011, 5'b00001};
    tbl[12] = '{5'b01100, 3'b111, 5'b00100};
    tbl[13] = '{5'b00000, 3'b111, 5'b00000};
    tbl[14] = '{5'b00010, 3'b111, 5'b00010};

    rst   = 1'b1;
    req   = '0;
    cdata = '0;

    // Reset with all requesting: grant forced low.
    step(1'b1, 5'b11111, 3'b111, 5'b00000, 1'b0);
    step(1'b1, 5'b11111, 3'b111, 5'b00000, 1'b0);

    // Single MUL commit.
    step(1'b0, 5'b01000, 3'b111, 5'b01000, 1'b1);
    step(1'b0, 5'b00000, 3'b111, 5'b00000, 1'b0);
    chk("mul_rsid",  {124'b0, rsid_o}, 128'd4);
    chk("mul_count", {112'b0, cnt_o},  128'd1);
    chk("mul_data",  {32'b0, data_o},  {32'b0, 32'd1, 32'd2, 32'd3});
    chk("mul_we",    {127'b0, we_o},   128'd1);

    for (int i = 0; i < 15; i++)
      step(1'b0, tbl[i].req, tbl[i].we, tbl[i].exp_gnt, 1'b0);

    // Reset in the cycle after a DIV grant discards it; DIV re-granted after.
    step(1'b0, 5'b00100, 3'b111, 5'b00100, 1'b0);
    step(1'b1, 5'b00100, 3'b111, 5'b00000, 1'b0);
    step(1'b1, 5'b00100, 3'b111, 5'b00000, 1'b0);
    step(1'b0, 5'b00100, 3'b111, 5'b00100, 1'b0);
    step(1'b0, 5'b00000, 3'b111, 5'b00000, 1'b0);
    chk("post_rst_count", {112'b0, cnt_o}, 128'd1);

    // Count wrap after 65536 commits, all stations requesting.
    step(1'b1, 5'b00000, 3'b111, 5'b00000, 1'b0);
    for (int i = 0; i < 65536; i++)
      step(1'b0, 5'b11111, 3'(i), model_gnt(5'b11111, mptr), 1'b0);
    step(1'b0, 5'b00000, 3'b111, 5'b00000, 1'b0);
    chk("wrap_count", {112'b0, cnt_o}, 128'd0);
    step(1'b0, 5'b00000, 3'b111, 5'b00000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
